// File: rtl/mips_control_unit.sv
// Multi-cycle main control FSM for the MIPS datapath: fetch/decode, the core
// instruction subset, and opcode/overflow exceptions vectored through memory.
module mips_control_unit #(
    parameter int RESET_SP = 227
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       overflow,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic       AB_Load,
    output logic       MDR_Load,
    output logic       ALUOutCtrl,
    output logic       EPCControl,
    output logic [2:0] IorD,
    output logic [2:0] RegDst,
    output logic [3:0] MemtoReg,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ALUOp,
    output logic [2:0] PCSource,
    output logic [1:0] BranchCtrl,
    output logic [5:0] state
);

    // The stack pointer lives in the datapath; it must address the byte memory.
    if (RESET_SP < 0 || RESET_SP > 255) begin : g_bad_sp
        $error("RESET_SP outside the memory range");
    end

    typedef enum logic [5:0] {
        S_RESET     = 6'd0,
        S_FETCH     = 6'd1,
        S_FETCH_W   = 6'd2,
        S_IR_LOAD   = 6'd3,
        S_DECODE    = 6'd4,
        S_R_ALU     = 6'd5,
        S_R_WB      = 6'd6,
        S_ADDI      = 6'd7,
        S_I_WB      = 6'd8,
        S_MEM_ADDR  = 6'd9,
        S_LW_READ   = 6'd10,
        S_LW_WAIT   = 6'd11,
        S_LW_WB     = 6'd12,
        S_SW_WRITE  = 6'd13,
        S_BRANCH    = 6'd14,
        S_JUMP      = 6'd15,
        S_JAL_LINK  = 6'd16,
        S_JR        = 6'd17,
        S_RTE       = 6'd18,
        S_EXC       = 6'd19,
        S_EXC_WAIT  = 6'd20,
        S_EXC_JUMP  = 6'd21
    } state_t;

    state_t r_state;
    state_t w_next;
    logic   r_cause;      // 1 = overflow, 0 = bad opcode
    logic   w_next_cause;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_RESET;
            r_cause <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_next == S_EXC && r_state != S_EXC) begin
                r_cause <= w_next_cause;
            end
        end
    end

    assign state = r_state;

    always_comb begin
        w_next       = S_FETCH;
        w_next_cause = 1'b0;
        PCWrite      = 1'b0;
        PCWriteCond  = 1'b0;
        MemWrite     = 1'b0;
        IRWrite      = 1'b0;
        RegWrite     = 1'b0;
        AB_Load      = 1'b0;
        MDR_Load     = 1'b0;
        ALUOutCtrl   = 1'b0;
        EPCControl   = 1'b0;
        IorD         = 3'd0;
        RegDst       = 3'd0;
        MemtoReg     = 4'd0;
        ALUSrcA      = 2'd0;
        ALUSrcB      = 2'd0;
        ALUOp        = 3'b000;
        PCSource     = 3'd0;
        BranchCtrl   = 2'd0;

        case (r_state)
            S_RESET: begin
                RegWrite = 1'b1;
                RegDst   = 3'd3;
                MemtoReg = 4'd3;
                w_next   = S_FETCH;
            end
            S_FETCH, S_FETCH_W: begin
                ALUSrcB = 2'd1;
                ALUOp   = 3'b001;
                w_next  = (r_state == S_FETCH) ? S_FETCH_W : S_IR_LOAD;
            end
            S_IR_LOAD: begin
                IRWrite = 1'b1;
                PCWrite = 1'b1;
                ALUSrcB = 2'd1;
                ALUOp   = 3'b001;
                w_next  = S_DECODE;
            end
            S_DECODE: begin
                AB_Load    = 1'b1;
                ALUSrcB    = 2'd3;
                ALUOp      = 3'b001;
                ALUOutCtrl = 1'b1;
                case (opcode)
                    6'h00: begin
                        case (funct)
                            6'h20, 6'h22, 6'h24: w_next = S_R_ALU;
                            6'h08:               w_next = S_JR;
                            6'h13:               w_next = S_RTE;
                            default:             w_next = S_EXC;
                        endcase
                    end
                    6'h08:        w_next = S_ADDI;
                    6'h23, 6'h2B: w_next = S_MEM_ADDR;
                    6'h04, 6'h05: w_next = S_BRANCH;
                    6'h02:        w_next = S_JUMP;
                    6'h03:        w_next = S_JAL_LINK;
                    default:      w_next = S_EXC;
                endcase
            end
            S_R_ALU: begin
                ALUSrcA    = 2'd1;
                ALUOutCtrl = 1'b1;
                case (funct)
                    6'h20:   ALUOp = 3'b001;
                    6'h22:   ALUOp = 3'b010;
                    6'h24:   ALUOp = 3'b011;
                    default: ALUOp = 3'b000;
                endcase
                // Logical AND cannot overflow; only add/sub trap.
                if (overflow && (funct == 6'h20 || funct == 6'h22)) begin
                    w_next       = S_EXC;
                    w_next_cause = 1'b1;
                end else begin
                    w_next = S_R_WB;
                end
            end
            S_R_WB: begin
                RegWrite = 1'b1;
                RegDst   = 3'd1;
            end
            S_ADDI, S_MEM_ADDR: begin
                ALUSrcA    = 2'd1;
                ALUSrcB    = 2'd2;
                ALUOp      = 3'b001;
                ALUOutCtrl = 1'b1;
                if (r_state == S_MEM_ADDR) begin
                    w_next = (opcode == 6'h2B) ? S_SW_WRITE : S_LW_READ;
                end else if (overflow) begin
                    w_next       = S_EXC;
                    w_next_cause = 1'b1;
                end else begin
                    w_next = S_I_WB;
                end
            end
            S_I_WB: begin
                RegWrite = 1'b1;
            end
            S_LW_READ: begin
                IorD   = 3'd1;
                w_next = S_LW_WAIT;
            end
            S_LW_WAIT: begin
                IorD     = 3'd1;
                MDR_Load = 1'b1;
                w_next   = S_LW_WB;
            end
            S_LW_WB: begin
                RegWrite = 1'b1;
                MemtoReg = 4'd1;
            end
            S_SW_WRITE: begin
                IorD     = 3'd1;
                MemWrite = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA     = 2'd1;
                ALUOp       = 3'b010;
                PCWriteCond = 1'b1;
                PCSource    = 3'd1;
                BranchCtrl  = (opcode == 6'h05) ? 2'd1 : 2'd0;
            end
            S_JUMP: begin
                PCWrite  = 1'b1;
                PCSource = 3'd2;
            end
            S_JAL_LINK: begin
                RegWrite = 1'b1;
                RegDst   = 3'd2;
                MemtoReg = 4'd2;
                w_next   = S_JUMP;
            end
            S_JR: begin
                ALUSrcA = 2'd1;
                PCWrite = 1'b1;
            end
            S_RTE: begin
                PCWrite  = 1'b1;
                PCSource = 3'd3;
            end
            S_EXC: begin
                EPCControl = 1'b1;
                ALUSrcB    = 2'd1;
                ALUOp      = 3'b010;
                IorD       = r_cause ? 3'd3 : 3'd2;
                w_next     = S_EXC_WAIT;
            end
            S_EXC_WAIT: begin
                MDR_Load = 1'b1;
                IorD     = r_cause ? 3'd3 : 3'd2;
                w_next   = S_EXC_JUMP;
            end
            S_EXC_JUMP: begin
                PCWrite  = 1'b1;
                PCSource = 3'd4;
            end
            default: w_next = S_RESET;
        endcase
    end

endmodule

// File: tb/tb_mips_control_unit.sv
// Directed bench for mips_control_unit: walks each instruction class through
// its state sequence and checks the control word hand-derived per state.
module tb_mips_control_unit;

  logic       clock = 1'b0;
  logic       reset;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       overflow;
  logic       PCWrite, PCWriteCond, MemWrite, IRWrite, RegWrite;
  logic       AB_Load, MDR_Load, ALUOutCtrl, EPCControl;
  logic [2:0] IorD, RegDst, ALUOp, PCSource;
  logic [3:0] MemtoReg;
  logic [1:0] ALUSrcA, ALUSrcB, BranchCtrl;
  logic [5:0] state;

  int checks = 0;
  int failures = 0;

  mips_control_unit #(.RESET_SP(227)) dut (
    .clock(clock), .reset(reset), .opcode(opcode), .funct(funct),
    .overflow(overflow), .PCWrite(PCWrite), .PCWriteCond(PCWriteCond),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .RegWrite(RegWrite),
    .AB_Load(AB_Load), .MDR_Load(MDR_Load), .ALUOutCtrl(ALUOutCtrl),
    .EPCControl(EPCControl), .IorD(IorD), .RegDst(RegDst),
    .MemtoReg(MemtoReg), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALUOp(ALUOp), .PCSource(PCSource), .BranchCtrl(BranchCtrl),
    .state(state)
  );

  // clock / reset
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drives one instruction's opcode/funct and walks FETCH..DECODE.
  task automatic fetch_decode(input logic [5:0] op, input logic [5:0] fn);
    opcode = op;
    funct  = fn;
    tick();
    chk("fetch_state", 32'(state), 1);
    chk("fetch_iord", 32'(IorD), 0);
    chk("fetch_srcb", 32'(ALUSrcB), 1);
    chk("fetch_aluop", 32'(ALUOp), 1);
    chk("fetch_irwrite", 32'(IRWrite), 0);
    tick();
    chk("fwait_state", 32'(state), 2);
    chk("fwait_irwrite", 32'(IRWrite), 0);
    tick();
    chk("irload_state", 32'(state), 3);
    chk("irload_irwrite", 32'(IRWrite), 1);
    chk("irload_pcwrite", 32'(PCWrite), 1);
    chk("irload_pcsrc", 32'(PCSource), 0);
    tick();
    chk("decode_state", 32'(state), 4);
    chk("decode_irwrite", 32'(IRWrite), 0);
    chk("decode_abload", 32'(AB_Load), 1);
    chk("decode_srcb", 32'(ALUSrcB), 3);
    chk("decode_aluoutctrl", 32'(ALUOutCtrl), 1);
  endtask

  task automatic r_type(input logic [5:0] fn, input logic [2:0] exp_op, input logic ovf);
    fetch_decode(6'h00, fn);
    tick();
    chk("ralu_state", 32'(state), 5);
    chk("ralu_aluop", 32'(ALUOp), 32'(exp_op));
    chk("ralu_srca", 32'(ALUSrcA), 1);
    chk("ralu_srcb", 32'(ALUSrcB), 0);
    chk("ralu_regwrite", 32'(RegWrite), 0);
    overflow = ovf;
    tick();
    overflow = 1'b0;
    chk("rwb_state", 32'(state), 6);
    chk("rwb_regwrite", 32'(RegWrite), 1);
    chk("rwb_regdst", 32'(RegDst), 1);
    chk("rwb_memtoreg", 32'(MemtoReg), 0);
  endtask

  initial begin
    reset = 1'b1; opcode = 6'h00; funct = 6'h00; overflow = 1'b0;

    // reset held three cycles
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("reset_state", 32'(state), 0);
      chk("reset_regwrite", 32'(RegWrite), 1);
      chk("reset_regdst", 32'(RegDst), 3);
      chk("reset_memtoreg", 32'(MemtoReg), 3);
      chk("reset_memwrite", 32'(MemWrite), 0);
    end
    reset = 1'b0;

    // add, sub, and (and ignores overflow)
    r_type(6'h20, 3'b001, 1'b0);
    r_type(6'h22, 3'b010, 1'b0);
    r_type(6'h24, 3'b011, 1'b1);
    fetch_decode(6'h23, 6'h00);   // ensures R_WB returned to FETCH
    tick();
    chk("lw_addr_state", 32'(state), 9);
    chk("lw_addr_mdr", 32'(MDR_Load), 0);
    tick();
    chk("lw_read_state", 32'(state), 10);
    chk("lw_read_iord", 32'(IorD), 1);
    chk("lw_read_mdr", 32'(MDR_Load), 0);
    tick();
    chk("lw_wait_state", 32'(state), 11);
    chk("lw_wait_iord", 32'(IorD), 1);
    chk("lw_wait_mdr", 32'(MDR_Load), 1);
    tick();
    chk("lw_wb_state", 32'(state), 12);
    chk("lw_wb_regwrite", 32'(RegWrite), 1);
    chk("lw_wb_memtoreg", 32'(MemtoReg), 1);
    chk("lw_wb_regdst", 32'(RegDst), 0);
    chk("lw_wb_mdr", 32'(MDR_Load), 0);

    // sw with overflow during address calc: ignored
    fetch_decode(6'h2B, 6'h00);
    tick();
    chk("sw_addr_state", 32'(state), 9);
    chk("sw_addr_srcb", 32'(ALUSrcB), 2);
    overflow = 1'b1;
    tick();
    overflow = 1'b0;
    chk("sw_state", 32'(state), 13);
    chk("sw_memwrite", 32'(MemWrite), 1);
    chk("sw_iord", 32'(IorD), 1);
    tick();
    chk("sw_done_state", 32'(state), 1);
    chk("sw_done_memwrite", 32'(MemWrite), 0);
    tick(); tick(); tick();

    // addi without overflow; DUT sits in DECODE after these ticks
    opcode = 6'h08;
    tick();
    chk("addi_state", 32'(state), 7);
    chk("addi_srcb", 32'(ALUSrcB), 2);
    tick();
    chk("iwb_state", 32'(state), 8);
    chk("iwb_regwrite", 32'(RegWrite), 1);
    chk("iwb_regdst", 32'(RegDst), 0);

    // addi with overflow -> exception with cause=overflow
    fetch_decode(6'h08, 6'h00);
    tick();
    chk("addi_ovf_state", 32'(state), 7);
    overflow = 1'b1;
    tick();
    overflow = 1'b0;
    chk("exc_ovf_state", 32'(state), 19);
    chk("exc_ovf_iord", 32'(IorD), 3);
    chk("exc_ovf_epc", 32'(EPCControl), 1);
    chk("exc_ovf_srcb", 32'(ALUSrcB), 1);
    chk("exc_ovf_aluop", 32'(ALUOp), 2);
    chk("exc_ovf_regwrite", 32'(RegWrite), 0);
    tick();
    chk("excw_ovf_state", 32'(state), 20);
    chk("excw_ovf_iord", 32'(IorD), 3);
    chk("excw_ovf_mdr", 32'(MDR_Load), 1);
    chk("excw_ovf_epc", 32'(EPCControl), 0);
    chk("excw_ovf_regwrite", 32'(RegWrite), 0);
    tick();
    chk("excj_state", 32'(state), 21);
    chk("excj_pcwrite", 32'(PCWrite), 1);
    chk("excj_pcsrc", 32'(PCSource), 4);
    chk("excj_regwrite", 32'(RegWrite), 0);

    // beq then bne
    fetch_decode(6'h04, 6'h00);
    tick();
    chk("beq_state", 32'(state), 14);
    chk("beq_cond", 32'(PCWriteCond), 1);
    chk("beq_pcsrc", 32'(PCSource), 1);
    chk("beq_bctrl", 32'(BranchCtrl), 0);
    chk("beq_pcwrite", 32'(PCWrite), 0);
    chk("beq_aluop", 32'(ALUOp), 2);
    fetch_decode(6'h05, 6'h00);
    chk("bne_prev_cond", 32'(PCWriteCond), 0);
    tick();
    chk("bne_state", 32'(state), 14);
    chk("bne_cond", 32'(PCWriteCond), 1);
    chk("bne_bctrl", 32'(BranchCtrl), 1);
    chk("bne_pcwrite", 32'(PCWrite), 0);

    // j, jal, jr, rte
    fetch_decode(6'h02, 6'h00);
    tick();
    chk("j_state", 32'(state), 15);
    chk("j_pcwrite", 32'(PCWrite), 1);
    chk("j_pcsrc", 32'(PCSource), 2);
    fetch_decode(6'h03, 6'h00);
    tick();
    chk("jal_state", 32'(state), 16);
    chk("jal_regwrite", 32'(RegWrite), 1);
    chk("jal_regdst", 32'(RegDst), 2);
    chk("jal_memtoreg", 32'(MemtoReg), 2);
    tick();
    chk("jal_jump_state", 32'(state), 15);
    fetch_decode(6'h00, 6'h08);
    tick();
    chk("jr_state", 32'(state), 17);
    chk("jr_srca", 32'(ALUSrcA), 1);
    chk("jr_aluop", 32'(ALUOp), 0);
    chk("jr_pcwrite", 32'(PCWrite), 1);
    chk("jr_pcsrc", 32'(PCSource), 0);
    fetch_decode(6'h00, 6'h13);
    tick();
    chk("rte_state", 32'(state), 18);
    chk("rte_pcsrc", 32'(PCSource), 3);

    // sub overflow -> exception (cause=overflow)
    fetch_decode(6'h00, 6'h22);
    tick();
    overflow = 1'b1;
    tick();
    overflow = 1'b0;
    chk("sub_ovf_state", 32'(state), 19);
    chk("sub_ovf_iord", 32'(IorD), 3);

    // illegal opcode -> exception (cause=opcode); reset mid-exception
    tick(); tick();
    fetch_decode(6'h3F, 6'h00);
    tick();
    chk("exc_op_state", 32'(state), 19);
    chk("exc_op_iord", 32'(IorD), 2);
    tick();
    chk("excw_op_state", 32'(state), 20);
    chk("excw_op_iord", 32'(IorD), 2);
    chk("excw_op_mdr", 32'(MDR_Load), 1);
    reset = 1'b1;
    tick();
    chk("rst_exc_state", 32'(state), 0);
    chk("rst_exc_mdr", 32'(MDR_Load), 0);
    chk("rst_exc_pcwrite", 32'(PCWrite), 0);
    reset = 1'b0;
    tick();
    chk("after_rst_state", 32'(state), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
